// File: rtl/spcpu_mem_arbiter_if.sv
// Request/response bus between the two requesting masters, the arbiter and
// the external memory.
interface spcpu_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              p0_req, p0_we, p0_sz, p0_rdy, p0_err;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata, p0_rdata;
  logic              p1_req, p1_we, p1_sz, p1_rdy, p1_err;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata, p1_rdata;
  logic              mem_req, mem_we, mem_sz, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  // master: the arbiter (owns the memory side, answers both ports)
  modport master (
    input  p0_req, p0_we, p0_sz, p0_addr, p0_wdata,
    output p0_rdata, p0_rdy, p0_err,
    input  p1_req, p1_we, p1_sz, p1_addr, p1_wdata,
    output p1_rdata, p1_rdy, p1_err,
    output mem_req, mem_we, mem_sz, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    output p0_req, p0_we, p0_sz, p0_addr, p0_wdata,
    input  p0_rdata, p0_rdy, p0_err,
    output p1_req, p1_we, p1_sz, p1_addr, p1_wdata,
    input  p1_rdata, p1_rdy, p1_err,
    input  mem_req, mem_we, mem_sz, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/spcpu_mem_arbiter.sv
// Round-robin two-port memory arbiter with a bus-timeout watchdog.
// One transaction at a time: IDLE -> BUSY -> DONE -> IDLE.
module spcpu_mem_arbiter_port #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              done,
  input  logic              err_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] rdata,
  output logic              rdy,
  output logic              err
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
      rdy   <= 1'b0;
      err   <= 1'b0;
    end else begin
      rdy <= done;
      err <= done & err_in;
      if (done) rdata <= err_in ? '1 : data_in;
    end
  end
endmodule

module spcpu_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  spcpu_mem_arbiter_if.master bus,
  output logic                busy,
  output logic                grant
);
  localparam int          CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int          RW   = ADDR_W + DATA_W + 2;
  localparam logic [CW:0] TO_V = (CW+1)'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [CW:0]            cnt_inc;
  logic                   last_grant, win, to_hit, fin;
  logic [1:0]             req, fin_p, rdy_p, err_p;
  logic [1:0][RW-1:0]     fld;
  logic [1:0][DATA_W-1:0] rdata_p;

  assign req    = {bus.p1_req, bus.p0_req};
  assign fld[0] = {bus.p0_we, bus.p0_sz, bus.p0_addr, bus.p0_wdata};
  assign fld[1] = {bus.p1_we, bus.p1_sz, bus.p1_addr, bus.p1_wdata};

  // Tie goes to the port that did not win last time
  assign win     = (&req) ? ~last_grant : ~req[0];
  assign cnt_inc = {1'b0, cnt} + (CW+1)'(1);
  // mem_ready on the deadline cycle wins over the watchdog
  assign to_hit  = (TIMEOUT != 0) && !bus.mem_ready && (cnt_inc == TO_V);
  assign fin     = (state == BUSY) && (bus.mem_ready || to_hit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      busy          <= 1'b0;
      grant         <= 1'b0;
      last_grant    <= 1'b1;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_sz    <= 1'b1;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          grant       <= win;
          {bus.mem_we, bus.mem_sz, bus.mem_addr, bus.mem_wdata} <= fld[win];
          bus.mem_req <= 1'b1;
          cnt         <= '0;
          busy        <= 1'b1;
          state       <= BUSY;
        end
        BUSY: if (fin) begin
          bus.mem_req <= 1'b0;
          state       <= DONE;
        end else if (TIMEOUT != 0) begin
          cnt <= cnt_inc[CW-1:0];
        end
        DONE: begin
          last_grant <= grant;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_port
    assign fin_p[i] = fin && (grant == 1'(i));
    spcpu_mem_arbiter_port #(.DATA_W(DATA_W)) u_port (
      .clk    (clk),
      .reset  (reset),
      .done   (fin_p[i]),
      .err_in (~bus.mem_ready),
      .data_in(bus.mem_rdata),
      .rdata  (rdata_p[i]),
      .rdy    (rdy_p[i]),
      .err    (err_p[i])
    );
  end

  assign bus.p0_rdata = rdata_p[0];
  assign bus.p0_rdy   = rdy_p[0];
  assign bus.p0_err   = err_p[0];
  assign bus.p1_rdata = rdata_p[1];
  assign bus.p1_rdy   = rdy_p[1];
  assign bus.p1_err   = err_p[1];
endmodule

// File: doc/spcpu_mem_arbiter.md
# spcpu_mem_arbiter

Two-port arbiter sharing the single external memory bus between the CPU core's load/store/fetch port (port 0) and a secondary master such as a DMA or debug loader (port 1). It accepts a request from either port and presents one transaction at a time on the memory side. It returns read data and a one-cycle ready pulse to the winning port. Fairness is round-robin, and a bus-timeout watchdog ensures a dead memory cannot hang the CPU.

## Interface
Parameters:
- ADDR_W, 16, address width (matches CPU address width)
- DATA_W, 16, data width (16-bit access bus; 8-bit accesses use the low byte)
- TIMEOUT, 15, number of BUSY cycles allowed without mem_ready before abort; 0 disables the watchdog

Ports:
- clk  in  1  sole clock, all logic on rising edge
- reset  in  1  asynchronous, active-low (0 = in reset); assertion acts immediately, deassertion is synchronous to clk
- p0_req / p1_req  in  1  port requests transaction; held high with fields stable until that port's rdy pulse
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_sz / p1_sz  in  1  access size, 0 = 8-bit, 1 = 16-bit
- p0_addr / p1_addr  in  ADDR_W  byte address
- p0_wdata / p1_wdata  in  DATA_W  write data
- p0_rdata / p1_rdata  out  DATA_W  registered read data, valid while that port's rdy is high, held afterwards
- p0_rdy / p1_rdy  out  1  one-cycle completion pulse
- p0_err / p1_err  out  1  high with rdy when the transaction timed out
- mem_req  out  1  memory transaction request
- mem_we, mem_sz  out  1  registered copies of the winner's we/sz
- mem_addr  out  ADDR_W  registered winner address
- mem_wdata  out  DATA_W  registered winner write data
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready = 1
- mem_ready  in  1  memory completion, one cycle
- busy  out  1  high in BUSY and DONE
- grant  out  1  index of current or last granted port

## Operation
- States are IDLE, BUSY and DONE.
- **IDLE:** if neither req is high, stay in IDLE. If exactly one is high, grant it. If both are high, grant the port that is not `last_grant` (round-robin).
  - On grant: latch the winner's addr, we, sz and wdata into the mem_* registers; set mem_req = 1; clear the timeout counter; go to BUSY.
  - mem_ready is ignored in IDLE.
- **BUSY:** mem_req stays high and the mem_* fields stay stable.
  - On mem_ready = 1: capture mem_rdata into the winner's rdata (reads and writes alike); drop mem_req; set the winner's rdy = 1 and err = 0; go to DONE.
  - Otherwise, if TIMEOUT ≠ 0, increment the counter. When the counter reaches TIMEOUT: drop mem_req; load the winner's rdata with all-ones; set rdy = 1 and err = 1; go to DONE.
  - If mem_ready arrives on the same cycle the counter reaches TIMEOUT, it completes normally (err = 0).
  - A requester deasserting req during BUSY is ignored; the transaction completes and rdy still pulses.
- **DONE:** rdy/err are high for exactly this cycle. Set `last_grant` = winner and go to IDLE. A req still high in the next IDLE cycle is a new request.
- The losing port's rdy, err and rdata are untouched during the transaction.
- Counter width is ceil(log2(TIMEOUT+1)) bits. The counter saturates and never wraps.

## Timing
- **Reset values:**
  - mem_req, mem_we, p*_rdy, p*_err, busy = 0
  - mem_sz = 1 (16-bit)
  - mem_addr, mem_wdata, p*_rdata = 0
  - grant = 0
  - `last_grant` = 1, so port 0 wins the first tie
  - state = IDLE
- **Latency:**
  - req sampled high in IDLE at edge N → mem_req high from cycle N+1.
  - mem_ready sampled at edge M → mem_req low and rdy high in cycle M+1 → IDLE in cycle M+2.
  - Minimum transaction is 3 cycles (req → rdy → next grant possible).
- **Reset mid-operation:** mem_req and rdy drop asynchronously. A mem_ready arriving after reset deassertion, while in IDLE, is ignored.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- **Single port-0 read:** reset; p0_req = 1, addr = 16'h0100, sz = 1, we = 0; mem_ready after 2 BUSY cycles with mem_rdata = 16'hBEEF → mem_addr = 16'h0100; p0_rdy one cycle with p0_rdata = 16'hBEEF and p0_err = 0; p1_rdy never asserts.
- **Simultaneous requests, both held:** p0 and p1 both request, zero-wait memory → grants alternate 0, 1, 0, 1 across 4 transactions, each 3 cycles apart.
- **Port-1 write:** p1 writes 16'h1234 to 16'h8000 with sz = 0 → mem_we = 1, mem_sz = 0, mem_wdata = 16'h1234 stable for all of BUSY; p1_rdy pulses.
- **Timeout:** TIMEOUT = 15; mem_ready held 0 → after 15 BUSY cycles mem_req drops, p0_rdy = 1 and p0_err = 1, p0_rdata = 16'hFFFF. Repeat with mem_ready arriving on the 15th cycle → err = 0 and the real data is returned.
- **Reset mid-BUSY:** pull reset low while mem_req = 1 → mem_req = 0 in the same cycle with no rdy pulse. Release reset, then pulse mem_ready → ignored, state remains IDLE.
- **Req drop during BUSY:** drop p0_req one cycle after grant → transaction completes and p0_rdy still pulses once; no re-grant follows.
